// File: rtl/pipeline_hazard_unit.sv
// rtl/pipeline_hazard_unit.sv - in-order pipeline hazard detection, forwarding select and redirect flush control
module pipeline_hazard_unit #(
  parameter int ADDR_W         = 5,
  parameter int FWD_EN         = 1,
  parameter int REDIRECT_FLUSH = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              freeze_i,
  input  logic              id_valid_i,
  input  logic [ADDR_W-1:0] id_rs1_i,
  input  logic [ADDR_W-1:0] id_rs2_i,
  input  logic              id_uses_rs1_i,
  input  logic              id_uses_rs2_i,
  input  logic [ADDR_W-1:0] id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              ex_redirect_i,
  input  logic              clr_counters_i,
  output logic              stall_o,
  output logic              flush_if_id_o,
  output logic              flush_id_ex_o,
  output logic [1:0]        fwd_a_o,
  output logic [1:0]        fwd_b_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] rd;
    logic              reg_write;
    logic              mem_read;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  localparam logic [1:0] FLUSH_RELOAD = 2'(REDIRECT_FLUSH - 1);

  entry_t     ex_q, mem_q, wb_q;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic hazard, redirect, bubble;

  // A producer only counts when it really writes a non-zero register the consumer reads
  function automatic logic src_match(input entry_t e, input logic used, input logic [ADDR_W-1:0] src);
    return used && e.valid && e.reg_write && (e.rd == src) && (e.rd != '0);
  endfunction

  // Youngest producer wins; a WB match reads the written-through regfile value
  function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_mem, input logic hit_wb);
    if (hit_ex)       return 2'b01;
    else if (hit_mem) return 2'b10;
    else if (hit_wb)  return 2'b00;
    else              return 2'b00;
  endfunction

  assign ex_hit_a  = src_match(ex_q,  id_uses_rs1_i, id_rs1_i);
  assign ex_hit_b  = src_match(ex_q,  id_uses_rs2_i, id_rs2_i);
  assign mem_hit_a = src_match(mem_q, id_uses_rs1_i, id_rs1_i);
  assign mem_hit_b = src_match(mem_q, id_uses_rs2_i, id_rs2_i);
  assign wb_hit_a  = src_match(wb_q,  id_uses_rs1_i, id_rs1_i);
  assign wb_hit_b  = src_match(wb_q,  id_uses_rs2_i, id_rs2_i);

  assign redirect = ex_redirect_i && !freeze_i;
  assign bubble   = stall_o || flush_id_ex_o || !id_valid_i;

  // Hazard: load-use only when forwarding, any in-flight producer otherwise
  always_comb begin
    hazard = 1'b0;
    if (FWD_EN != 0) begin
      hazard = id_valid_i && ex_q.mem_read && (ex_hit_a || ex_hit_b);
    end else begin
      hazard = id_valid_i && (ex_hit_a || ex_hit_b || mem_hit_a || mem_hit_b);
    end
  end

  // Control outputs and redirect FSM next state; freeze dominates, redirect beats hazard
  always_comb begin
    stall_o       = 1'b0;
    flush_if_id_o = 1'b0;
    flush_id_ex_o = 1'b0;
    state_d       = state_q;
    cnt_d         = cnt_q;
    if (!reset) begin
      if (freeze_i) begin
        stall_o = 1'b1;
      end else begin
        if (ex_redirect_i) begin
          flush_if_id_o = 1'b1;
          flush_id_ex_o = 1'b1;
          if (REDIRECT_FLUSH > 1) begin
            state_d = FLUSH;
            cnt_d   = FLUSH_RELOAD;
          end else begin
            state_d = RUN;
            cnt_d   = 2'd0;
          end
        end else begin
          if (hazard) begin
            stall_o       = 1'b1;
            flush_id_ex_o = 1'b1;
          end
          if (state_q == FLUSH) begin
            flush_if_id_o = 1'b1;
            if (cnt_q <= 2'd1) begin
              state_d = RUN;
              cnt_d   = 2'd0;
            end else begin
              cnt_d = cnt_q - 2'd1;
            end
          end
        end
      end
    end
  end

  // FSM state and flush down-counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Tracker shift and registered forwarding selects, held while frozen
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_o <= 2'b00;
      fwd_b_o <= 2'b00;
    end else if (!freeze_i) begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      if (bubble) begin
        ex_q <= '0;
      end else begin
        ex_q <= '{valid: 1'b1, rd: id_rd_i, reg_write: id_reg_write_i, mem_read: id_mem_read_i};
      end
      if (bubble || (FWD_EN == 0)) begin
        fwd_a_o <= 2'b00;
        fwd_b_o <= 2'b00;
      end else begin
        fwd_a_o <= fwd_sel(ex_hit_a, mem_hit_a, wb_hit_a);
        fwd_b_o <= fwd_sel(ex_hit_b, mem_hit_b, wb_hit_b);
      end
    end
  end

  // Saturating performance counters; clear wins over increment
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else if (clr_counters_i) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (stall_o && (stall_cnt_o != '1)) begin
        stall_cnt_o <= stall_cnt_o + CNT_W'(1);
      end
      if (redirect && (flush_cnt_o != '1)) begin
        flush_cnt_o <= flush_cnt_o + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// tb/tb_pipeline_hazard_unit.sv - self-checking bench for pipeline_hazard_unit (forwarding and interlock builds)
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       freeze, id_valid, uses1, uses2, reg_write, mem_read, redirect, clr;
  logic [4:0] rs1, rs2, rd;

  logic       f_stall, f_fie, f_fidex;
  logic [1:0] f_fa, f_fb;
  logic [3:0] f_sc, f_fc;
  logic       s_stall, s_fie, s_fidex;
  logic [1:0] s_fa, s_fb;
  logic [15:0] s_sc, s_fc;

  int total = 0;
  int bad   = 0;

  // model state, index 0 = forwarding build, 1 = interlock build; stage 0 EX, 1 MEM, 2 WB
  bit mv [2][3];
  int mrd[2][3];
  bit mrw[2][3];
  bit mmr[2][3];
  int mfa[2], mfb[2], mleft[2], msc[2], mfc[2];

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.ADDR_W(5), .FWD_EN(1), .REDIRECT_FLUSH(3), .CNT_W(4)) dut_f (
    .clk(clk), .reset(rst), .freeze_i(freeze), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .id_rd_i(rd), .id_reg_write_i(reg_write), .id_mem_read_i(mem_read),
    .ex_redirect_i(redirect), .clr_counters_i(clr),
    .stall_o(f_stall), .flush_if_id_o(f_fie), .flush_id_ex_o(f_fidex),
    .fwd_a_o(f_fa), .fwd_b_o(f_fb), .stall_cnt_o(f_sc), .flush_cnt_o(f_fc));

  pipeline_hazard_unit #(.ADDR_W(5), .FWD_EN(0), .REDIRECT_FLUSH(1), .CNT_W(16)) dut_s (
    .clk(clk), .reset(rst), .freeze_i(freeze), .id_valid_i(id_valid),
    .id_rs1_i(rs1), .id_rs2_i(rs2), .id_uses_rs1_i(uses1), .id_uses_rs2_i(uses2),
    .id_rd_i(rd), .id_reg_write_i(reg_write), .id_mem_read_i(mem_read),
    .ex_redirect_i(redirect), .clr_counters_i(clr),
    .stall_o(s_stall), .flush_if_id_o(s_fie), .flush_id_ex_o(s_fidex),
    .fwd_a_o(s_fa), .fwd_b_o(s_fb), .stall_cnt_o(s_sc), .flush_cnt_o(s_fc));

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit hit(input int k, input int s, input int src, input bit used);
    return used && (src != 0) && mv[k][s] && mrw[k][s] && (mrd[k][s] == src);
  endfunction

  // Model: decide this cycle's controls from the in-flight instruction list, compare, then advance
  task automatic model_step(input int k);
    bit fw, a_st, a_fie, a_fdx, hz, e_st, e_fie, e_fdx, bub;
    bit h1e, h2e, h1m, h2m;
    int rf, cmax, a_fa, a_fb, a_sc, a_fc;
    string p;
    fw   = (k == 0);
    rf   = (k == 0) ? 3 : 1;
    cmax = (k == 0) ? 15 : 65535;
    p    = (k == 0) ? "fwd" : "ilk";
    a_st  = (k == 0) ? f_stall : s_stall;
    a_fie = (k == 0) ? f_fie : s_fie;
    a_fdx = (k == 0) ? f_fidex : s_fidex;
    a_fa  = (k == 0) ? int'(f_fa) : int'(s_fa);
    a_fb  = (k == 0) ? int'(f_fb) : int'(s_fb);
    a_sc  = (k == 0) ? int'(f_sc) : int'(s_sc);
    a_fc  = (k == 0) ? int'(f_fc) : int'(s_fc);
    if (rst) begin
      for (int s = 0; s < 3; s++) begin
        mv[k][s] = 0; mrd[k][s] = 0; mrw[k][s] = 0; mmr[k][s] = 0;
      end
      mfa[k] = 0; mfb[k] = 0; mleft[k] = 0; msc[k] = 0; mfc[k] = 0;
    end
    h1e = hit(k, 0, int'(rs1), uses1);
    h2e = hit(k, 0, int'(rs2), uses2);
    h1m = hit(k, 1, int'(rs1), uses1);
    h2m = hit(k, 1, int'(rs2), uses2);
    hz  = id_valid && (fw ? (mmr[k][0] && (h1e || h2e)) : (h1e || h2e || h1m || h2m));
    e_st  = !rst && (freeze || (hz && !redirect));
    e_fie = !rst && !freeze && (redirect || (mleft[k] > 0));
    e_fdx = !rst && !freeze && (redirect || hz);
    chk({p, "_stall"}, a_st, e_st);
    chk({p, "_flush_if_id"}, a_fie, e_fie);
    chk({p, "_flush_id_ex"}, a_fdx, e_fdx);
    chk({p, "_fwd_a"}, a_fa, mfa[k]);
    chk({p, "_fwd_b"}, a_fb, mfb[k]);
    chk({p, "_stall_cnt"}, a_sc, msc[k]);
    chk({p, "_flush_cnt"}, a_fc, mfc[k]);
    if (!rst) begin
      if (clr) begin
        msc[k] = 0; mfc[k] = 0;
      end else begin
        if (e_st && msc[k] < cmax) msc[k]++;
        if (redirect && !freeze && mfc[k] < cmax) mfc[k]++;
      end
      if (!freeze) begin
        bub = e_st || e_fdx || !id_valid;
        if (bub || !fw) begin
          mfa[k] = 0; mfb[k] = 0;
        end else begin
          mfa[k] = h1e ? 1 : (h1m ? 2 : 0);
          mfb[k] = h2e ? 1 : (h2m ? 2 : 0);
        end
        for (int s = 2; s > 0; s--) begin
          mv[k][s] = mv[k][s-1]; mrd[k][s] = mrd[k][s-1];
          mrw[k][s] = mrw[k][s-1]; mmr[k][s] = mmr[k][s-1];
        end
        mv[k][0]  = !bub;
        mrd[k][0] = bub ? 0 : int'(rd);
        mrw[k][0] = !bub && reg_write;
        mmr[k][0] = !bub && mem_read;
        if (redirect) mleft[k] = rf - 1;
        else if (mleft[k] > 0) mleft[k]--;
      end
    end
  endtask

  // Single compare process, mid-cycle
  always @(negedge clk) begin
    model_step(0);
    model_step(1);
  end

  task automatic cyc(input bit v, input int a, input bit ua, input int b, input bit ub,
                     input int d, input bit rw, input bit mr, input bit rdr, input bit frz, input bit cl);
    @(posedge clk);
    #1;
    id_valid = v; rs1 = 5'(a); uses1 = ua; rs2 = 5'(b); uses2 = ub;
    rd = 5'(d); reg_write = rw; mem_read = mr; redirect = rdr; freeze = frz; clr = cl;
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1;
    freeze = 0; id_valid = 0; uses1 = 0; uses2 = 0; reg_write = 0; mem_read = 0;
    redirect = 0; clr = 0; rs1 = 0; rs2 = 0; rd = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_stall", f_stall, 0);
    chk("reset_cnt", f_sc, 0);
    rst = 1'b0;
    idle(2);

    // load x5 then add x6,x5,x7
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cyc(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0);
    chk("lu_stall", f_stall, 1);
    chk("lu_flush_id_ex", f_fidex, 1);
    cyc(1, 5, 1, 7, 1, 6, 1, 0, 0, 0, 0);
    chk("lu_release", f_stall, 0);
    idle(1);
    chk("lu_fwd_a", f_fa, 2);
    chk("lu_stall_cnt", f_sc, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(2);

    // add x5 then sub x8,x9,x5
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    cyc(1, 9, 1, 5, 1, 8, 1, 0, 0, 0, 0);
    chk("ex_fwd_nostall", f_stall, 0);
    chk("ilk_stall_1", s_stall, 1);
    cyc(1, 9, 1, 5, 1, 8, 1, 0, 0, 0, 0);
    chk("ex_fwd_b", f_fb, 1);
    chk("ilk_stall_2", s_stall, 1);
    cyc(1, 9, 1, 5, 1, 8, 1, 0, 0, 0, 0);
    chk("ilk_stall_3", s_stall, 0);
    idle(1);
    chk("ilk_fwd_b", s_fb, 0);
    chk("ilk_stall_cnt", s_sc, 2);
    idle(3);

    // redirect together with load-use
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cyc(1, 5, 1, 7, 1, 6, 1, 0, 1, 0, 0);
    chk("rd_stall", f_stall, 0);
    chk("rd_fie_0", f_fie, 1);
    chk("rd_fidex", f_fidex, 1);
    idle(1);
    chk("rd_fie_1", f_fie, 1);
    idle(1);
    chk("rd_fie_2", f_fie, 1);
    idle(1);
    chk("rd_fie_3", f_fie, 0);
    chk("rd_flush_cnt", f_fc, 1);

    // redirect with clear, then freeze 4 cycles inside FLUSH
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      chk("frz_fie", f_fie, 0);
      chk("frz_stall", f_stall, 1);
    end
    idle(1);
    chk("frz_resume_fie", f_fie, 1);
    chk("frz_stall_cnt", f_sc, 4);
    chk("frz_flush_cnt", f_fc, 0);
    idle(1);
    chk("frz_fie_last", f_fie, 1);
    idle(1);
    chk("frz_fie_done", f_fie, 0);

    // x0 producer never hazards
    cyc(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    cyc(1, 0, 1, 0, 1, 3, 1, 0, 0, 0, 0);
    chk("x0_stall_f", f_stall, 0);
    chk("x0_stall_s", s_stall, 0);
    idle(1);
    chk("x0_fwd_a", f_fa, 0);

    // saturation and clear-wins
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    idle(1);
    chk("sat_f", f_sc, 15);
    chk("sat_s", s_sc, 20);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    idle(1);
    chk("clr_f", f_sc, 0);
    chk("clr_s", s_sc, 0);

    // reset in the middle of FLUSH
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    @(posedge clk);
    #1;
    redirect = 0;
    rst = 1'b1;
    #1;
    chk("rstmid_fie", f_fie, 0);
    chk("rstmid_stall", f_stall, 0);
    chk("rstmid_fidex", f_fidex, 0);
    chk("rstmid_fc", f_fc, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("post_rst_fie", f_fie, 0);
    cyc(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0);
    cyc(1, 5, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    chk("post_rst_lu", f_stall, 1);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
